// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Counter must index WIDTH-1; keep at least one bit for tiny widths.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_sub_fs.sv
// Structural one-bit full subtractor: diff = a^b^bin,
// bout = (~a & b) | (~(a^b) & bin). Built from gate primitives only.
module serial_sub_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic axb;
  logic na;
  logic naxb;
  logic borrow_gen;
  logic borrow_prop;

  xor g_axb  (axb, a, b);
  xor g_diff (diff, axb, bin);
  not g_na   (na, a);
  not g_naxb (naxb, axb);
  and g_gen  (borrow_gen, na, b);
  and g_prop (borrow_prop, naxb, bin);
  or  g_bout (bout, borrow_gen, borrow_prop);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, one bit per clock,
// with start/busy/done handshake. Optional signed-overflow output: SERIAL_SUB_OVF_EN.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] ash;
  logic [WIDTH-1:0] bsh;
  logic [WIDTH-2:0] rsh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             fs_diff;
  logic             fs_bout;
  logic [WIDTH-1:0] res_next;

  serial_sub_fs u_fs (
    .a    (ash[0]),
    .b    (bsh[0]),
    .bin  (borrow),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  // rsh holds only the upper WIDTH-1 bits of the result shifter; the newest
  // diff bit completes it, so the final step loads d straight from res_next.
  assign res_next = {fs_diff, rsh};

  assign busy = (state == S_CALC);
  assign done = (state == S_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      ash    <= '0;
      bsh    <= '0;
      rsh    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (start) begin
            ash    <= a;
            bsh    <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= S_CALC;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_CALC: begin
          rsh    <= res_next[WIDTH-1:1];
          borrow <= fs_bout;
          ash    <= ash >> 1;
          bsh    <= bsh >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            d     <= res_next;
            bout  <= fs_bout;
`ifdef SERIAL_SUB_OVF_EN
            // On the last step ash[0]/bsh[0] are the operand sign bits.
            ovf   <= (ash[0] ^ bsh[0]) & (fs_diff ^ ash[0]);
`endif
            state <= S_FIN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vector table plus hand-written
// sequences for mid-operation START, back-to-back operation and async reset.
module tb_serial_sub;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int tests;
  int fails;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] expD;
    logic             expBout;
    logic             expOvf;
  } vec_t;

  vec_t vecs[8];

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present operands with START for exactly one accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb);
    @(negedge clk);
    a     = ta;
    b     = tb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count busy negedges until DONE is seen, bounded by a cycle budget.
  task automatic waitDone(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    for (int k = 0; k < 3 * WIDTH && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) cycles++;
    end
  endtask

  initial begin
    int  bc;
    bit  seen;
    int  dones;
    logic [WIDTH-1:0] dval;

    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0] = '{8'd5,   8'd3,   8'd2,   1'b0, 1'b0};
    vecs[1] = '{8'd3,   8'd5,   8'hFE,  1'b1, 1'b0};
    vecs[2] = '{8'h00,  8'hFF,  8'h01,  1'b1, 1'b0};
    vecs[3] = '{8'hA5,  8'hA5,  8'h00,  1'b0, 1'b0};
    vecs[4] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
    vecs[5] = '{8'h05,  8'h03,  8'h02,  1'b0, 1'b0};
    vecs[6] = '{8'hFF,  8'h00,  8'hFF,  1'b0, 1'b0};
    vecs[7] = '{8'h7F,  8'h80,  8'hFF,  1'b1, 1'b1};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_d",    32'(d),    32'd0);
    checkOutput("reset_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("reset_ovf",  32'(ovf),  32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      waitDone(bc, seen);
      checkOutput($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'(WIDTH));
      checkOutput($sformatf("vec%0d_done_seen", i), 32'(seen), 32'd1);
      checkOutput($sformatf("vec%0d_d", i), 32'(d), 32'(vecs[i].expD));
      checkOutput($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].expBout));
`ifdef SERIAL_SUB_OVF_EN
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].expOvf));
`endif
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      checkOutput($sformatf("vec%0d_d_hold", i), 32'(d), 32'(vecs[i].expD));
    end

    // START re-pulsed mid-CALC must be ignored.
    applyStimulus(8'd20, 8'd7);
    checkOutput("midstart_d_held", 32'(d), 32'hFF);
    repeat (3) @(negedge clk);
    a     = 8'd100;
    b     = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    dval  = '0;
    for (int k = 0; k < 3 * WIDTH; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        dval = d;
      end
    end
    checkOutput("midstart_dones", 32'(dones), 32'd1);
    checkOutput("midstart_d", 32'(dval), 32'd13);

    // START held through FIN: second operation without an IDLE bubble.
    @(negedge clk);
    a     = 8'd7;
    b     = 8'd2;
    start = 1'b1;
    waitDone(bc, seen);
    checkOutput("b2b_first_done", 32'(seen), 32'd1);
    checkOutput("b2b_first_d", 32'(d), 32'd5);
    a = 8'd10;
    b = 8'd4;
    @(negedge clk);
    checkOutput("b2b_no_bubble", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone(bc, seen);
    checkOutput("b2b_second_done", 32'(seen), 32'd1);
    checkOutput("b2b_done_gap", 32'(bc + 2), 32'(WIDTH + 1));
    checkOutput("b2b_second_d", 32'(d), 32'd6);
    checkOutput("b2b_second_bout", 32'(bout), 32'd0);

    // Asynchronous reset in the middle of CALC.
    applyStimulus(8'd3, 8'd5);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_done", 32'(done), 32'd0);
    checkOutput("rstmid_d",    32'(d),    32'd0);
    checkOutput("rstmid_bout", 32'(bout), 32'd0);
    #1 rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checkOutput("rstmid_no_done", 32'(dones), 32'd0);
    applyStimulus(8'd9, 8'd4);
    waitDone(bc, seen);
    checkOutput("rstmid_after_cycles", 32'(bc), 32'(WIDTH));
    checkOutput("rstmid_after_done", 32'(seen), 32'd1);
    checkOutput("rstmid_after_d", 32'(d), 32'd5);
    checkOutput("rstmid_after_bout", 32'(bout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
